// File: rtl/mealy_fsm_counter.sv
// mealy_fsm_counter
//   Free-running WIDTH-bit state counter that emits a one-cycle strobe once
//   every 2**WIDTH clocks. It serves as a periodic phase marker for downstream
//   logic.
//
// Parameters
//   WIDTH        state/counter width; the cycle length is 2**WIDTH states
//   MATCH_STATE  state value during which out is high (must be < 2**WIDTH)
//
// Ports
//   clk    system clock; all state updates occur on the rising edge
//   reset  synchronous, active-high reset (takes priority over counting)
//   out    high while the current state equals MATCH_STATE, low otherwise
module mealy_fsm_counter #(
    parameter int unsigned           WIDTH       = 2,
    parameter logic [WIDTH-1:0]      MATCH_STATE = WIDTH'(2'b10)
) (
    input  logic clk,
    input  logic reset,
    output logic out
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic             out_q;

    // The counter wraps naturally at 2**WIDTH.
    always_comb begin
        state_next = state + WIDTH'(1);
    end

    // out is registered from the value that state is about to take. This
    // keeps it aligned with the current state: it is high in exactly the
    // cycles where state == MATCH_STATE, and it does not glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
            out_q <= (MATCH_STATE == '0);
        end else begin
            state <= state_next;
            out_q <= (state_next == MATCH_STATE);
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mealy_fsm_counter.sv
module tb_mealy_fsm_counter;

    localparam int unsigned WIDTH  = 2;
    localparam int unsigned PERIOD = 1 << WIDTH;
    localparam int unsigned MATCH  = 2;

    logic clk;
    logic reset;
    logic out;

    int unsigned checks;
    int unsigned failures;

    mealy_fsm_counter #(
        .WIDTH      (WIDTH),
        .MATCH_STATE(WIDTH'(MATCH))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit exp_out;
    } vec_t;

    task automatic check(input string name, input logic actual, input bit expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: out=%b expected=%b at time %0t", name, actual, expected, $time);
        end
    endtask

    // Apply reset for one rising edge, then sample out 1 time unit after that edge.
    task automatic step(input bit r);
        reset = r;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    int unsigned since;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;

        // Expected out after each edge. Counting from the release of reset:
        // states 01,10,11,00,... so out pattern 0,1,0,0 repeats.
        vecs.push_back('{1, 0});
        vecs.push_back('{1, 0});
        // Twelve edges from S0: out high on edges 2, 6 and 10 only.
        for (int i = 1; i <= 12; i++)
            vecs.push_back('{0, ((i % PERIOD) == MATCH)});
        // Mid-run reset while in S0 after wrap; run into S2 first.
        vecs.push_back('{0, 0});  // S1
        vecs.push_back('{0, 1});  // S2, out high
        vecs.push_back('{1, 0});  // reset from S2 gives S0
        vecs.push_back('{0, 0});  // resumes at S1
        vecs.push_back('{0, 1});  // S2

        foreach (vecs[i]) begin
            step(vecs[i].rst);
            check($sformatf("vec%0d", i), out, vecs[i].exp_out);
        end

        // Reset held for 5 edges, starting from S2 (out high).
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("held_reset%0d", i), out, 0);
        end

        // Reset pulsed only between edges must have no effect.
        step(0);                 // S1
        check("pulse_pre", out, 0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        check("pulse_mid", out, 0);
        @(posedge clk);
        #1;                      // S2 expected, not S0
        check("pulse_s2", out, 1);
        step(0);                 // S3
        check("pulse_s3", out, 0);

        // Randomized reset stimulus against an edge-count reference model:
        // out is high when the number of edges since reset is congruent to
        // MATCH modulo the cycle length.
        step(1);
        since = 0;
        for (int i = 0; i < 300; i++) begin
            bit r;
            r = ($urandom_range(0, 9) == 0);
            step(r);
            if (r) since = 0;
            else   since++;
            check("random", out, ((since % PERIOD) == MATCH));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
